// File: rtl/quick_sort_ic.sv
// In-place quicksort engine: Lomuto partitioning driven by an explicit lo/hi stack over an internal register file.
// Optional feature macro QSORT_RANGE_CHECK_EN adds an err output that rejects start bounds outside the array.
module quick_sort_ic #(
    parameter int WORD_SIZE = 16,
    parameter int DEPTH     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [WORD_SIZE-1:0]       A,
    input  logic [WORD_SIZE-1:0]       lo,
    input  logic [WORD_SIZE-1:0]       hi,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [WORD_SIZE-1:0]       wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [WORD_SIZE-1:0]       rd_data,
    output logic                       busy,
    output logic                       done
`ifdef QSORT_RANGE_CHECK_EN
    ,
    output logic                       err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] ONE = AW'(1);
    localparam logic [AW:0]   P1  = (AW+1)'(1);

    typedef enum logic [2:0] {IDLE, POP, CHECK, SCAN, PUSH, DONE} state_t;

    state_t state, state_next;

    logic [WORD_SIZE-1:0] reg_file [DEPTH];

    // Stack holds lo/hi pairs; pending sub-ranges are disjoint with >= 2 elements, so DEPTH pairs never overflow.
    logic [AW-1:0] stack_lo [DEPTH];
    logic [AW-1:0] stack_hi [DEPTH];
    logic [AW:0]   stack_pointer;

    logic [AW-1:0]        lo_reg, hi_reg, i, j;
    logic [WORD_SIZE-1:0] pivot, temp;

    logic [AW-1:0] eff_lo, eff_hi;
    logic [AW-1:0] pop_idx, push_idx, right_idx;
    logic          accept, reject;
    logic          stack_empty;
    logic          push_left, push_right;
    logic          less, do_swap;

    assign eff_lo = AW'(A + lo);
    assign eff_hi = AW'(A + hi);

    assign accept = start && ((state == IDLE) || (state == DONE));

`ifdef QSORT_RANGE_CHECK_EN
    logic [WORD_SIZE:0] full_lo, full_hi;
    logic               range_bad;

    assign full_lo   = {1'b0, A} + {1'b0, lo};
    assign full_hi   = {1'b0, A} + {1'b0, hi};
    assign range_bad = (full_lo >= (WORD_SIZE+1)'(DEPTH)) || (full_hi >= (WORD_SIZE+1)'(DEPTH));
    assign reject    = accept && range_bad;
`else
    assign reject = 1'b0;
`endif

    assign stack_empty = (stack_pointer == '0);
    assign pop_idx     = AW'(stack_pointer - P1);
    assign push_idx    = AW'(stack_pointer);
    assign push_left   = {1'b0, i} > ({1'b0, lo_reg} + P1);
    assign push_right  = ({1'b0, i} + P1) < {1'b0, hi_reg};
    assign right_idx   = push_left ? AW'(stack_pointer + P1) : push_idx;

    // The last scan step (j == hi) swaps the pivot into its final slot using the same i/j swap path.
    assign less    = reg_file[j] < pivot;
    assign temp    = reg_file[i];
    assign do_swap = (state == SCAN) && (less || (j == hi_reg));

    assign busy    = (state != IDLE) && (state != DONE);
    assign done    = (state == DONE);
    assign rd_data = reg_file[rd_addr];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_next = reject ? DONE : POP;
                end
            end
            POP:     state_next = stack_empty ? DONE : CHECK;
            CHECK:   state_next = (lo_reg < hi_reg) ? SCAN : POP;
            SCAN:    state_next = (j == hi_reg) ? PUSH : SCAN;
            PUSH:    state_next = POP;
            default: state_next = IDLE;
        endcase
    end

    // Working registers and stack pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stack_pointer <= '0;
            lo_reg        <= '0;
            hi_reg        <= '0;
            pivot         <= '0;
            i             <= '0;
            j             <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept && !reject) begin
                        stack_pointer <= P1;
                    end
                end
                POP: begin
                    if (!stack_empty) begin
                        lo_reg        <= stack_lo[pop_idx];
                        hi_reg        <= stack_hi[pop_idx];
                        stack_pointer <= stack_pointer - P1;
                    end
                end
                CHECK: begin
                    if (lo_reg < hi_reg) begin
                        pivot <= reg_file[hi_reg];
                        i     <= lo_reg;
                        j     <= lo_reg;
                    end
                end
                SCAN: begin
                    if (j != hi_reg) begin
                        if (less) begin
                            i <= i + ONE;
                        end
                        j <= j + ONE;
                    end
                end
                PUSH: begin
                    stack_pointer <= stack_pointer + {{AW{1'b0}}, push_left} + {{AW{1'b0}}, push_right};
                end
                default: ;
            endcase
        end
    end

    // Stack storage; the left sub-range is pushed below the right one so the right is partitioned first.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (accept && !reject) begin
                stack_lo[push_idx] <= eff_lo;
                stack_hi[push_idx] <= eff_hi;
            end else if (state == PUSH) begin
                if (push_left) begin
                    stack_lo[push_idx] <= lo_reg;
                    stack_hi[push_idx] <= i - ONE;
                end
                if (push_right) begin
                    stack_lo[right_idx] <= i + ONE;
                    stack_hi[right_idx] <= hi_reg;
                end
            end
        end
    end

    // Array storage survives reset; host writes only land while the engine is not sorting.
    always_ff @(posedge clk) begin
        if (rst_n && do_swap) begin
            reg_file[i] <= reg_file[j];
            reg_file[j] <= temp;
        end else if (wr_en && !busy) begin
            reg_file[wr_addr] <= wr_data;
        end
    end

`ifdef QSORT_RANGE_CHECK_EN
    // Error flag reflects the most recent start request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (accept) begin
            err <= range_bad;
        end
    end
`endif

endmodule

// File: tb/tb_quick_sort_ic.sv
// Self-checking bench for quick_sort_ic: a reference array model sorted by insertion sort, checked on every
// read sweep, plus hand-computed literal results. Exercises QSORT_RANGE_CHECK_EN when that macro is defined.
module tb_quick_sort_ic;

    localparam int WS    = 16;
    localparam int DEPTH = 16;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          start   = 1'b0;
    logic [WS-1:0] A       = '0;
    logic [WS-1:0] lo      = '0;
    logic [WS-1:0] hi      = '0;
    logic          wr_en   = 1'b0;
    logic [3:0]    wr_addr = '0;
    logic [WS-1:0] wr_data = '0;
    logic [3:0]    rd_addr = '0;
    logic [WS-1:0] rd_data;
    logic          busy;
    logic          done;
`ifdef QSORT_RANGE_CHECK_EN
    logic          err;
`endif

    int checks = 0;
    int errors = 0;

    logic          cmp_en   = 1'b0;
    logic          exp_busy = 1'b0;
    logic          exp_done = 1'b0;
    logic [WS-1:0] model_mem [DEPTH];

    logic [WS-1:0] first_data  [10] = '{55, 8, 34, 6, 5, 22, 33, 2, 1, 13};
    logic [WS-1:0] exp_sorted1 [10] = '{1, 2, 5, 6, 8, 13, 22, 33, 34, 55};
    logic [WS-1:0] exp_sub     [5]  = '{5, 6, 22, 33, 34};
    logic [WS-1:0] dup_data    [5]  = '{7, 3, 7, 3, 7};
    logic [WS-1:0] exp_dup     [5]  = '{3, 3, 7, 7, 7};

    quick_sort_ic #(.WORD_SIZE(WS), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .A       (A),
        .lo      (lo),
        .hi      (hi),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done)
`ifdef QSORT_RANGE_CHECK_EN
        ,
        .err     (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Compare process: whenever a sweep is in progress, the read port must match the model array.
    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("rd_data_vs_model", {16'd0, rd_data}, {16'd0, model_mem[rd_addr]});
            checkOutput("busy_vs_model", {31'd0, busy}, {31'd0, exp_busy});
            checkOutput("done_vs_model", {31'd0, done}, {31'd0, exp_done});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadWord(input int addr, input logic [WS-1:0] data);
        wr_en   = 1'b1;
        wr_addr = addr[3:0];
        wr_data = data;
        tick();
        model_mem[addr] = data;
        wr_en = 1'b0;
    endtask

    task automatic loadFirstData();
        for (int k = 0; k < 10; k++) loadWord(k, first_data[k]);
        for (int k = 10; k < DEPTH; k++) loadWord(k, WS'(16'h0100 + k));
    endtask

    // Reference result: the inclusive range [l,h] of the model sorted ascending.
    task automatic modelSort(input int l, input int h);
        for (int x = l + 1; x <= h; x++) begin
            logic [WS-1:0] key;
            int y;
            key = model_mem[x];
            y = x - 1;
            while (y >= l && model_mem[y] > key) begin
                model_mem[y+1] = model_mem[y];
                y--;
            end
            model_mem[y+1] = key;
        end
    endtask

    task automatic startOnly(input int a, input int l, input int h);
        A     = WS'(a);
        lo    = WS'(l);
        hi    = WS'(h);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(inout int cycles);
        while (!done && cycles < 3000) begin
            checkOutput("busy_while_sorting", {31'd0, busy}, 32'd1);
            tick();
            cycles++;
        end
        checkOutput("done_reached", {31'd0, done}, 32'd1);
        checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic applyStimulus(input int a, input int l, input int h, output int cycles);
        startOnly(a, l, h);
        cycles = 1;
        checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
        checkOutput("done_cleared_by_start", {31'd0, done}, 32'd0);
        waitDone(cycles);
    endtask

    task automatic sweepRead();
        exp_busy = 1'b0;
        exp_done = 1'b1;
        cmp_en   = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = a[3:0];
            tick();
        end
        cmp_en = 1'b0;
    endtask

    task automatic pinWord(input string name, input int addr, input logic [WS-1:0] val);
        rd_addr = addr[3:0];
        #1;
        checkOutput(name, {16'd0, rd_data}, {16'd0, val});
    endtask

    initial begin
        int cyc;

        rst_n = 1'b0;
        tick();
        tick();
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
`ifdef QSORT_RANGE_CHECK_EN
        checkOutput("reset_err", {31'd0, err}, 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        $display("[TB] full sort of ten words");
        loadFirstData();
        applyStimulus(0, 0, 9, cyc);
        modelSort(0, 9);
        sweepRead();
        for (int k = 0; k < 10; k++) pinWord("full_sort_word", k, exp_sorted1[k]);
        pinWord("full_sort_untouched_10", 10, 16'h010A);

        $display("[TB] already sorted input");
        for (int k = 0; k < 10; k++) loadWord(k, WS'(k));
        applyStimulus(0, 0, 9, cyc);
        checkOutput("sorted_latency_le_85", {31'd0, (cyc <= 85)}, 32'd1);
        sweepRead();
        for (int k = 0; k < 10; k++) pinWord("sorted_unchanged", k, WS'(k));

        $display("[TB] sub-range A=2 lo=0 hi=4");
        loadFirstData();
        applyStimulus(2, 0, 4, cyc);
        modelSort(2, 6);
        sweepRead();
        for (int k = 0; k < 5; k++) pinWord("subrange_word", 2 + k, exp_sub[k]);
        pinWord("subrange_below", 1, 16'd8);
        pinWord("subrange_above", 7, 16'd2);

        $display("[TB] duplicates with ignored write and start while busy");
        for (int k = 0; k < 5; k++) loadWord(k, dup_data[k]);
        startOnly(0, 0, 4);
        wr_en   = 1'b1;
        wr_addr = 4'd12;
        wr_data = 16'hBEEF;
        A       = '0;
        lo      = '0;
        hi      = WS'(15);
        start   = 1'b1;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        cyc   = 2;
        waitDone(cyc);
        modelSort(0, 4);
        sweepRead();
        for (int k = 0; k < 5; k++) pinWord("dup_word", k, exp_dup[k]);
        pinWord("busy_write_dropped", 12, 16'h010C);

        $display("[TB] degenerate ranges");
        applyStimulus(0, 5, 5, cyc);
        sweepRead();
`ifdef QSORT_RANGE_CHECK_EN
        checkOutput("degenerate_err", {31'd0, err}, 32'd0);
`endif
        applyStimulus(0, 6, 2, cyc);
        sweepRead();
`ifdef QSORT_RANGE_CHECK_EN
        checkOutput("inverted_err", {31'd0, err}, 32'd0);
`endif

        $display("[TB] reset during scan, then re-sort");
        loadFirstData();
        startOnly(0, 0, 9);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        checkOutput("midsort_reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("midsort_reset_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        tick();
        applyStimulus(0, 0, 9, cyc);
        modelSort(0, 9);
        sweepRead();
        for (int k = 0; k < 10; k++) pinWord("resort_word", k, exp_sorted1[k]);

`ifdef QSORT_RANGE_CHECK_EN
        $display("[TB] out-of-range start");
        loadFirstData();
        startOnly(10, 0, 9);
        checkOutput("range_err", {31'd0, err}, 32'd1);
        checkOutput("range_done", {31'd0, done}, 32'd1);
        checkOutput("range_busy", {31'd0, busy}, 32'd0);
        sweepRead();
        applyStimulus(0, 0, 1, cyc);
        checkOutput("range_err_cleared", {31'd0, err}, 32'd0);
        modelSort(0, 1);
        sweepRead();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
